// File: rtl/alu_ctrl_pkg.sv
// Shared RV32I encodings and ALU op codes for the pipelined ALU-control decoder.
package alu_ctrl_pkg;

  localparam logic [6:0] OPC_R_TYPE  = 7'b0110011;
  localparam logic [6:0] OPC_I_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_I_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_S_TYPE  = 7'b0100011;
  localparam logic [6:0] OPC_B_TYPE  = 7'b1100011;
  localparam logic [6:0] OPC_I_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_J_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_U_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_U_AUIPC = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASS_B = 5'd10,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  // f7-independent meaning of funct3 for register/immediate ALU ops (shift right resolves to SRL).
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      F3_ADD_SUB: op = ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SR:      op = ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I decode to ALU op, operand selects and illegal flag.
// Optional macro ALU_CTRL_MEXT_EN makes the M-extension R-type encodings legal.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  alu_op_o,
  output logic        src_a_pc_o,
  output logic        src_b_imm_o,
  output logic        illegal_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[14:12];
  assign f7  = instr_i[31:25];
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    alu_op_o    = ALU_ADD;
    src_a_pc_o  = 1'b0;
    src_b_imm_o = 1'b0;
    illegal_o   = 1'b0;
    case (opc)
      OPC_R_TYPE: begin
        if (f7 == F7_BASE) begin
          alu_op_o = base_op(f3);
        end else if (f7 == F7_ALT && f3 == F3_ADD_SUB) begin
          alu_op_o = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == F3_SR) begin
          alu_op_o = ALU_SRA;
        end else if (f7 == F7_MULDIV) begin
`ifdef ALU_CTRL_MEXT_EN
          alu_op_o = ALU_MUL | {2'b00, f3};
`else
          illegal_o = 1'b1;
`endif
        end else begin
          illegal_o = 1'b1;
        end
      end
      OPC_I_IMM: begin
        src_b_imm_o = 1'b1;
        if (f3 == F3_SLL) begin
          if (f7 == F7_BASE) alu_op_o = ALU_SLL;
          else               illegal_o = 1'b1;
        end else if (f3 == F3_SR) begin
          if (f7 == F7_BASE)     alu_op_o = ALU_SRL;
          else if (f7 == F7_ALT) alu_op_o = ALU_SRA;
          else                   illegal_o = 1'b1;
        end else begin
          alu_op_o = base_op(f3);
        end
      end
      OPC_I_LOAD, OPC_S_TYPE, OPC_I_JALR: begin
        src_b_imm_o = 1'b1;
      end
      OPC_B_TYPE: begin
        alu_op_o = ALU_SUB;
      end
      OPC_J_JAL, OPC_U_AUIPC: begin
        src_a_pc_o  = 1'b1;
        src_b_imm_o = 1'b1;
      end
      OPC_U_LUI: begin
        alu_op_o    = ALU_PASS_B;
        src_b_imm_o = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
    // Illegal encodings always present a neutral ADD with register operands.
    if (illegal_o) begin
      alu_op_o    = ALU_ADD;
      src_a_pc_o  = 1'b0;
      src_b_imm_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Pipelined ALU-control decoder: decode, PIPE_STAGES valid/ready register stages,
// flush and a saturating illegal-instruction counter. Optional macro: ALU_CTRL_MEXT_EN.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int PIPE_STAGES = 1,
  parameter int ALU_OP_W    = 5,
  parameter int TAG_W       = 8,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic                out_src_a_pc,
  output logic                out_src_b_imm,
  output logic                out_illegal,
  output logic [TAG_W-1:0]    out_tag,
  output logic [CNT_W-1:0]    illegal_cnt
);

  localparam int S = PIPE_STAGES;

  logic [4:0] dec_op;
  logic       dec_a_pc;
  logic       dec_b_imm;
  logic       dec_ill;
  logic       accept;

  alu_ctrl_decode u_decode (
    .instr_i     (in_instr),
    .alu_op_o    (dec_op),
    .src_a_pc_o  (dec_a_pc),
    .src_b_imm_o (dec_b_imm),
    .illegal_o   (dec_ill)
  );

  // Index 0 of each chain is the decoded input; index k+1 is the output of stage k.
  logic                vld_c [S+1];
  logic [ALU_OP_W-1:0] op_c  [S+1];
  logic                a_c   [S+1];
  logic                b_c   [S+1];
  logic                ill_c [S+1];
  logic [TAG_W-1:0]    tag_c [S+1];
  logic [S-1:0]        stg_vld;
  logic [S-1:0]        rdy;

  assign vld_c[0] = in_valid;
  assign op_c[0]  = ALU_OP_W'(dec_op);
  assign a_c[0]   = dec_a_pc;
  assign b_c[0]   = dec_b_imm;
  assign ill_c[0] = dec_ill;
  assign tag_c[0] = in_tag;

  assign in_ready = rdy[0];
  assign accept   = in_valid & rdy[0] & ~flush;

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic                valid_q, valid_d, load;
    logic [ALU_OP_W-1:0] op_q;
    logic                a_q, b_q, ill_q;
    logic [TAG_W-1:0]    tag_q;

    // Stage k can take data when any stage from k to the end has a bubble or the sink drains.
    assign rdy[k] = out_ready | ~(&stg_vld[S-1:k]);

    always_comb begin
      valid_d = valid_q;
      load    = 1'b0;
      if (flush) begin
        valid_d = 1'b0;
      end else if (rdy[k]) begin
        valid_d = vld_c[k];
        load    = vld_c[k];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        op_q    <= '0;
        a_q     <= 1'b0;
        b_q     <= 1'b0;
        ill_q   <= 1'b0;
        tag_q   <= '0;
      end else begin
        valid_q <= valid_d;
        if (load) begin
          op_q  <= op_c[k];
          a_q   <= a_c[k];
          b_q   <= b_c[k];
          ill_q <= ill_c[k];
          tag_q <= tag_c[k];
        end
      end
    end

    assign stg_vld[k]  = valid_q;
    assign vld_c[k+1]  = valid_q;
    assign op_c[k+1]   = op_q;
    assign a_c[k+1]    = a_q;
    assign b_c[k+1]    = b_q;
    assign ill_c[k+1]  = ill_q;
    assign tag_c[k+1]  = tag_q;
  end

  assign out_valid     = vld_c[S];
  assign out_alu_op    = op_c[S];
  assign out_src_a_pc  = a_c[S];
  assign out_src_b_imm = b_c[S];
  assign out_illegal   = ill_c[S];
  assign out_tag       = tag_c[S];

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counted at accept time, so entries flushed later remain counted.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && dec_ill && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Scoreboard bench for alu_ctrl_pipe (PIPE_STAGES=2, CNT_W=4) with a behavioural decode model.
module tb_alu_ctrl_pipe;

  localparam int S   = 2;
  localparam int OPW = 5;
  localparam int TW  = 8;
  localparam int CW  = 4;
`ifdef ALU_CTRL_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]    in_instr;
  logic [TW-1:0]  in_tag, out_tag;
  logic [OPW-1:0] out_alu_op;
  logic           out_src_a_pc, out_src_b_imm, out_illegal;
  logic [CW-1:0]  illegal_cnt;

  always #5 clk = ~clk;

  alu_ctrl_pipe #(.PIPE_STAGES(S), .ALU_OP_W(OPW), .TAG_W(TW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
    .out_src_a_pc(out_src_a_pc), .out_src_b_imm(out_src_b_imm),
    .out_illegal(out_illegal), .out_tag(out_tag), .illegal_cnt(illegal_cnt)
  );

  typedef struct packed {
    logic [4:0] op;
    logic       a;
    logic       b;
    logic       ill;
  } dec_t;

  typedef struct {
    dec_t          d;
    logic [TW-1:0] tag;
    int            acc;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   mcnt  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] f3_op(input logic [2:0] f3);
    logic [4:0] tab [8];
    tab = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
    return tab[f3];
  endfunction

  function automatic dec_t mk(input int op, input bit a, input bit b);
    dec_t r;
    r.op = op[4:0]; r.a = a; r.b = b; r.ill = 1'b0;
    return r;
  endfunction

  function automatic dec_t ref_dec(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    dec_t r;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    r = '{op: 5'd0, a: 1'b0, b: 1'b0, ill: 1'b1};
    if (op == 7'h33) begin
      if (f7 == 7'h00)                    r = mk(f3_op(f3), 0, 0);
      else if (f7 == 7'h20 && f3 == 3'd0) r = mk(1, 0, 0);
      else if (f7 == 7'h20 && f3 == 3'd5) r = mk(7, 0, 0);
      else if (f7 == 7'h01 && MEXT)       r = mk(16 + int'(f3), 0, 0);
    end else if (op == 7'h13) begin
      if (f3 == 3'd1) begin
        if (f7 == 7'h00) r = mk(2, 0, 1);
      end else if (f3 == 3'd5) begin
        if (f7 == 7'h00)      r = mk(6, 0, 1);
        else if (f7 == 7'h20) r = mk(7, 0, 1);
      end else begin
        r = mk(f3_op(f3), 0, 1);
      end
    end else if (op == 7'h03 || op == 7'h23 || op == 7'h67) r = mk(0, 0, 1);
    else if (op == 7'h63)                    r = mk(1, 0, 0);
    else if (op == 7'h6F || op == 7'h17)     r = mk(0, 1, 1);
    else if (op == 7'h37)                    r = mk(10, 0, 1);
    return r;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    logic [6:0]  op, f7;
    r = $urandom();
    case ($urandom_range(0, 10))
      0, 1, 2: op = 7'h33;
      3, 4:    op = 7'h13;
      5:       op = 7'h03;
      6:       op = 7'h63;
      7:       op = 7'h37;
      8:       op = 7'h6F;
      9:       op = 7'h17;
      default: return $urandom();
    endcase
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      default: f7 = r[31:25] ^ r[6:0];
    endcase
    return {f7, r[9:0], r[17:15], r[14:10], op};
  endfunction

  // Monitor + reference model: sample and update between clock edges.
  logic        prev_rst = 1'b0, prev_stall = 1'b0;
  logic [15:0] held;

  always @(negedge clk) begin
    logic exp_ready, exp_ov;
    dec_t d;
    ent_t e;
    if (rst) begin
      q.delete();
      mcnt       = 0;
      prev_rst   = 1'b1;
      prev_stall = 1'b0;
    end else begin
      if (prev_rst) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_payload", {out_alu_op, out_src_a_pc, out_src_b_imm, out_illegal, out_tag}, 0);
        chk("rst_cnt", illegal_cnt, 0);
      end
      exp_ready = (q.size() < S) || out_ready;
      exp_ov    = (q.size() > 0) && ((cyc - q[0].acc) >= S);
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, exp_ov);
      chk("illegal_cnt", illegal_cnt, mcnt);
      if (prev_stall)
        chk("hold_payload", {out_alu_op, out_src_a_pc, out_src_b_imm, out_illegal, out_tag}, held);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e = q.pop_front();
          chk("payload", {out_alu_op, out_src_a_pc, out_src_b_imm, out_illegal, out_tag},
              {e.d.op, e.d.a, e.d.b, e.d.ill, e.tag});
        end
      end
      prev_stall = out_valid && !out_ready && !flush;
      held       = {out_alu_op, out_src_a_pc, out_src_b_imm, out_illegal, out_tag};
      if (flush) begin
        q.delete();
      end else if (in_valid && exp_ready) begin
        d = ref_dec(in_instr);
        q.push_back('{d: d, tag: in_tag, acc: cyc});
        if (d.ill && mcnt < (2**CW - 1)) mcnt++;
      end
      prev_rst = 1'b0;
    end
    cyc++;
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [TW-1:0] tg,
                      input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_tag    = tg;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // sub, srai, lui streamed back to back
    step(1, 32'h40B50533, 8'h11, 1, 0);
    step(1, 32'h4050D513, 8'h22, 1, 0);
    step(1, 32'h12345537, 8'h33, 1, 0);
    repeat (3) step(0, 32'h0, 8'h0, 1, 0);

    // mul: legal only with the M extension
    step(1, 32'h02B50533, 8'h44, 1, 0);
    repeat (3) step(0, 32'h0, 8'h0, 1, 0);

    // back-pressure with three instructions offered
    step(1, 32'h00B50533, 8'h51, 0, 0);
    step(1, 32'h00A5F533, 8'h52, 0, 0);
    step(1, 32'h00C56533, 8'h53, 0, 0);
    step(1, 32'h00C56533, 8'h53, 0, 0);
    step(1, 32'h00C56533, 8'h53, 1, 0);
    repeat (4) step(0, 32'h0, 8'h0, 1, 0);

    // flush with two in flight and a new offer
    step(1, 32'h00B50533, 8'h61, 0, 0);
    step(1, 32'h0FF50513, 8'h62, 0, 0);
    step(1, 32'h12345537, 8'h63, 1, 1);
    repeat (3) step(0, 32'h0, 8'h0, 1, 0);

    // counter saturation
    for (int i = 0; i < 20; i++) step(1, 32'hFFFFFFFF, TW'(i), 1, 0);
    repeat (3) step(0, 32'h0, 8'h0, 1, 0);
    chk("cnt_saturated", illegal_cnt, 15);

    // reset during a stall with entries valid
    step(1, 32'h00B50533, 8'h71, 0, 0);
    step(1, 32'hFFFFFFFF, 8'h72, 0, 0);
    rst = 1'b1;
    step(1, 32'h00B50533, 8'h73, 0, 0);
    rst = 1'b0;
    repeat (2) step(0, 32'h0, 8'h0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic v, ordy, fl;
      logic [TW-1:0] tg;
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 29) == 0);
      tg   = TW'($urandom());
      step(v, rnd_instr(), tg, ordy, fl);
    end

    repeat (6) step(0, 32'h0, 8'h0, 1, 0);
    chk("drain_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
- Pipelined successor to the combinational ALU-op decoder.
- Takes a full 32-bit RV32I instruction and decodes it into ALU op, operand-source selects and an illegal flag.
- Carries the result through PIPE_STAGES registered stages with valid/ready handshake, flush and a saturating illegal-instruction counter.
- Sits between the fetch/issue buffer and the execute stage.

Parameters:
- PIPE_STAGES, 1, number of register stages (1 or 2); latency in cycles when not stalled.
- ALU_OP_W, 5, width of alu_op; must be >=5.
- TAG_W, 8, width of the sideband tag passed through unmodified.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  drop all in-flight entries and any input offered this cycle
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction
- in_tag  in  TAG_W  sideband (e.g. ROB/PC index)
- out_valid  out  1  decoded entry available
- out_ready  in  1  execute accepts
- out_alu_op  out  ALU_OP_W  ALU operation code
- out_src_a_pc  out  1  operand A = PC instead of rs1
- out_src_b_imm  out  1  operand B = immediate instead of rs2
- out_illegal  out  1  instruction not decodable
- out_tag  out  TAG_W  tag of the output entry
- illegal_cnt  out  CNT_W  count of accepted illegal instructions

Behaviour:
- Reset (sync, active-high; dominates flush and handshake):
  - all stage valids 0; out_* fields 0; illegal_cnt 0.
- Decode is combinational from in_instr:
  - op = [6:0], f3 = [14:12], f7 = [31:25].
  - Result is captured into stage 1 on an input handshake (in_valid & in_ready & !flush).
- Handshake:
  - Each stage k holds valid_k plus payload.
  - ready_k = !valid_k | ready_{k+1}; last stage uses out_ready.
  - in_ready = ready_1, combinational.
  - out_valid = valid of the last stage; outputs come directly from the last-stage registers.
  - The payload must hold stable while out_valid & !out_ready.
  - Full throughput: one instruction per cycle when out_ready stays 1. Latency is PIPE_STAGES cycles.
- Flush:
  - Clears all valids next cycle.
  - An input offered in the same cycle is not accepted and not counted.
  - in_ready is unaffected (it may read 1 during flush).
- Decode table (anything else -> out_illegal=1, alu_op=ADD, selects 0):
  - R 0110011, f7=0000000:
    - f3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - R 0110011, f7=0100000: only f3 000 SUB and f3 101 SRA are legal.
  - I-ALU 0010011 (src_b_imm=1):
    - f3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND; f7 ignored for these.
    - f3 001 requires f7=0000000 -> SLL.
    - f3 101 requires f7 = 0000000 (SRL) or 0100000 (SRA).
  - Load 0000011, store 0100011, JALR 1100111: ADD, src_b_imm=1.
  - Branch 1100011: SUB, selects 0.
  - JAL 1101111: ADD, src_a_pc=1, src_b_imm=1.
  - AUIPC 0010111: ADD, src_a_pc=1, src_b_imm=1.
  - LUI 0110111: PASS_B, src_b_imm=1.
- illegal_cnt:
  - +1 per input handshake whose decode is illegal.
  - Saturates at all-ones; no wrap.
  - Counts at accept, so later flushed entries stay counted.
- Stall/flush corner cases:
  - Stall with all stages full: in_ready=0, nothing overwritten.
  - out_ready=1 in the same cycle as a new accept: pipeline shifts, no bubble.

Optional Feature:
- Macro: ALU_CTRL_MEXT_EN.
- Defined: R-type with f7=0000001 decodes f3 000..111 to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (legal).
- Undefined: those encodings are illegal and are counted.

Decomposition:
- Package alu_ctrl_pkg holds:
  - opcode constants (R_TYPE, I_IMM, I_LOAD, S_TYPE, B_TYPE, I_JALR, J_JAL, U_LUI, U_AUIPC);
  - F3/F7 constants;
  - ALU op encodings: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASS_B 10, MUL..REMU 16..23.
- One sub-module: alu_ctrl_decode, purely combinational, instr -> {alu_op, src_a_pc, src_b_imm, illegal}. The top instantiates it and the PIPE_STAGES register chain.

Test Plan:
1. Reset, then stream 0x40B50533 (sub), 0x4050D513 (srai), 0x12345537 (lui) with out_ready=1 and PIPE_STAGES=2.
   -> Outputs SUB, SRA/imm, PASS_B/imm on cycles 2, 3, 4; tags preserved.
2. Instruction 0x02B50533 (mul):
   - with ALU_CTRL_MEXT_EN -> alu_op=16, illegal=0;
   - without -> illegal=1, illegal_cnt=1.
3. Hold out_ready=0 while sending 3 instructions.
   -> in_ready falls after PIPE_STAGES accepts; the first payload is stable. Release -> all 3 emerge in order with no loss or duplication.
4. Assert flush with 2 entries in flight and in_valid=1.
   -> Next cycle out_valid=0; the offered instruction is absent from later output.
5. Preload the counter near max (CNT_W=4) and feed 20 instructions of 0xFFFFFFFF.
   -> illegal_cnt saturates at 15.
6. Assert rst mid-stall with entries valid.
   -> Next cycle out_valid=0, illegal_cnt=0, all outputs 0.
